// File: rtl/poly_tone_mixer_pkg.sv
// poly_tone_mixer_pkg: shared FSM encoding, default widths and saturation helper
package poly_tone_mixer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_DIV_W    = 20;
    localparam int DEF_AMP_W    = 16;
    localparam int DEF_ENV_DIV  = 1024;
    localparam int DEF_ENV_STEP = 64;

    // Clamps v to the signed range of a w-bit word; callers truncate to w bits.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        return (v > hi) ? hi : (v < -hi - 32'sd1) ? -hi - 32'sd1 : v;
    endfunction

endpackage

// File: rtl/poly_tone_mixer_tone_channel.sv
// tone_channel: one square-wave voice with divider, gated attack/release envelope and pan latch
//   clk, rst   clock and synchronous active-high reset
//   i_tick     shared envelope tick
//   i_load     latches i_div/i_vol/i_pan and restarts the divider count
//   i_gate     note held
//   o_busy     registered state != IDLE
//   o_contrib  signed +env/-env by phase, 0 when idle or muted
//   o_pan      latched {left_en, right_en}
module tone_channel
    import poly_tone_mixer_pkg::*;
#(
    parameter int DIV_W    = DEF_DIV_W,
    parameter int AMP_W    = DEF_AMP_W,
    parameter int ENV_STEP = DEF_ENV_STEP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_tick,
    input  logic                    i_load,
    input  logic                    i_gate,
    input  logic [DIV_W-1:0]        i_div,
    input  logic [AMP_W-2:0]        i_vol,
    input  logic [1:0]              i_pan,
    output logic                    o_busy,
    output logic signed [AMP_W-1:0] o_contrib,
    output logic [1:0]              o_pan
);

    localparam logic [AMP_W-1:0] STEP = AMP_W'(ENV_STEP);

    state_t           r_state, w_next;
    logic [DIV_W-1:0] r_div, r_cnt;
    logic [AMP_W-2:0] r_vol;
    logic [1:0]       r_pan;
    logic             r_phase, r_busy;
    logic [AMP_W-1:0] r_env, w_env, w_vol;

    // A load in the same cycle as a transition makes the new volume the target.
    assign w_vol = i_load ? {1'b0, i_vol} : {1'b0, r_vol};

    always_comb begin
        w_next = r_state;
        w_env  = r_env;
        case (r_state)
            ST_IDLE:    w_next = i_gate ? ST_ATTACK : ST_IDLE;
            ST_ATTACK:  w_next = !i_gate ? ST_RELEASE : (r_env == w_vol) ? ST_SUSTAIN : ST_ATTACK;
            ST_SUSTAIN: w_next = i_gate ? ST_SUSTAIN : ST_RELEASE;
            default:    w_next = i_gate ? ST_ATTACK : (r_env == '0) ? ST_IDLE : ST_RELEASE;
        endcase
        // The envelope step follows the rule of the state being entered.
        if (i_tick)
            case (w_next)
                ST_ATTACK:  w_env = (r_env + STEP > w_vol) ? w_vol : r_env + STEP;
                ST_SUSTAIN: w_env = (r_env < w_vol) ? ((w_vol - r_env > STEP) ? r_env + STEP : w_vol)
                                                    : ((r_env - w_vol > STEP) ? r_env - STEP : w_vol);
                ST_RELEASE: w_env = (r_env > STEP) ? r_env - STEP : '0;
                default:    w_env = r_env;
            endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_env   <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_div   <= '0;
            r_vol   <= '0;
            r_pan   <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next != ST_IDLE;
            r_env   <= w_env;
            if (i_load) begin
                r_div <= i_div;
                r_vol <= i_vol;
                r_pan <= i_pan;
                r_cnt <= '0;
            end else if (r_cnt == r_div) begin
                r_cnt   <= '0;
                r_phase <= r_phase ^ (r_div != '0);
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

    assign o_contrib = (r_state == ST_IDLE || r_div == '0) ? '0 : r_phase ? $signed(r_env) : -$signed(r_env);
    assign o_busy    = r_busy;
    assign o_pan     = r_pan;

endmodule

// File: rtl/poly_tone_mixer.sv
// poly_tone_mixer: NUM_CH tone channels mixed with saturation into registered stereo samples
//   clk, rst              clock and synchronous active-high reset
//   ch_load, ch_gate      per-channel load pulse and gate level
//   note_div, volume, pan packed per-channel settings
//   ch_busy               per-channel state != IDLE
//   audio_left/right      signed saturated mix, one clock behind channel state
module poly_tone_mixer
    import poly_tone_mixer_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int AMP_W    = DEF_AMP_W,
    parameter int ENV_DIV  = DEF_ENV_DIV,
    parameter int ENV_STEP = DEF_ENV_STEP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_load,
    input  logic [NUM_CH-1:0]             ch_gate,
    input  logic [NUM_CH*DIV_W-1:0]       note_div,
    input  logic [NUM_CH*(AMP_W-1)-1:0]   volume,
    input  logic [NUM_CH*2-1:0]           pan,
    output logic [NUM_CH-1:0]             ch_busy,
    output logic signed [AMP_W-1:0]       audio_left,
    output logic signed [AMP_W-1:0]       audio_right
);

    localparam int PW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam int SW = AMP_W + $clog2(NUM_CH);

    logic [PW-1:0]           r_pre;
    logic                    w_tick;
    logic signed [AMP_W-1:0] w_con [NUM_CH];
    logic [1:0]              w_pan [NUM_CH];
    logic signed [SW-1:0]    w_sum_l, w_sum_r;
    logic signed [AMP_W-1:0] r_left, r_right;

    assign w_tick = r_pre == PW'(ENV_DIV - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel #(
            .DIV_W    (DIV_W),
            .AMP_W    (AMP_W),
            .ENV_STEP (ENV_STEP)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_tick    (w_tick),
            .i_load    (ch_load[i]),
            .i_gate    (ch_gate[i]),
            .i_div     (note_div[i*DIV_W +: DIV_W]),
            .i_vol     (volume[i*(AMP_W-1) +: AMP_W-1]),
            .i_pan     (pan[2*i +: 2]),
            .o_busy    (ch_busy[i]),
            .o_contrib (w_con[i]),
            .o_pan     (w_pan[i])
        );
    end

    // The sum is wide enough that it never wraps before saturation.
    always_comb begin
        w_sum_l = '0;
        w_sum_r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_pan[k][1]) w_sum_l = w_sum_l + SW'(w_con[k]);
            if (w_pan[k][0]) w_sum_r = w_sum_r + SW'(w_con[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_left  <= '0;
            r_right <= '0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + PW'(1);
            r_left  <= AMP_W'(sat_signed(32'(w_sum_l), AMP_W));
            r_right <= AMP_W'(sat_signed(32'(w_sum_r), AMP_W));
        end
    end

    assign audio_left  = r_left;
    assign audio_right = r_right;

endmodule

// File: tb/tb_poly_tone_mixer.sv
// tb_poly_tone_mixer: directed checks of envelope, divider, retrigger, panning, saturation and reset
module tb_poly_tone_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_load, ch_gate, ch_busy;
    logic [39:0] note_div;
    logic [29:0] volume;
    logic [3:0]  pan;
    logic [15:0] audio_left, audio_right;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    poly_tone_mixer #(
        .NUM_CH   (2),
        .DIV_W    (20),
        .AMP_W    (16),
        .ENV_DIV  (4),
        .ENV_STEP ('h1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_load     (ch_load),
        .ch_gate     (ch_gate),
        .note_div    (note_div),
        .volume      (volume),
        .pan         (pan),
        .ch_busy     (ch_busy),
        .audio_left  (audio_left),
        .audio_right (audio_right)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Returns at the falling edge after rising edge e; state seen is that after edge e.
    task automatic at(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic [19:0] d, input logic [14:0] v, input logic [1:0] p);
        note_div[c*20 +: 20] = d;
        volume[c*15 +: 15]   = v;
        pan[c*2 +: 2]        = p;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ch_load = '0; ch_gate = '0; note_div = '0; volume = '0; pan = '0;
        at(2);
        check("rst_busy", ch_busy, 2'b00);
        check("rst_left", audio_left, 16'h0000);
        check("rst_right", audio_right, 16'h0000);
        rst = 1'b0;
        set_ch(0, 20'd3, 15'h4000, 2'b11);
        ch_load = 2'b01; ch_gate = 2'b01;
        at(3);
        ch_load = '0;
        check("attack_busy", ch_busy, 2'b01);
        at(18);
        check("ramp_left", audio_left, 16'h3000);
        at(19);
        check("peak_left", audio_left, 16'h4000);
        check("peak_right", audio_right, 16'h4000);
        at(20);
        check("neg_left", audio_left, 16'hC000);
        check("neg_right", audio_right, 16'hC000);
        at(24);
        check("sustain_left", audio_left, 16'h4000);
        ch_gate = '0;
        at(31);
        check("release_left", audio_left, 16'hE000);
        at(38);
        check("rel_zero_busy", ch_busy, 2'b01);
        at(39);
        check("idle_busy", ch_busy, 2'b00);
        at(40);
        check("idle_left", audio_left, 16'h0000);
        ch_gate = 2'b01;
        at(55);
        ch_gate = '0;
        at(62);
        ch_gate = 2'b01;
        at(63);
        check("retrig_busy", ch_busy, 2'b01);
        at(64);
        check("retrig_keep_env", audio_left, 16'h2000);
        at(67);
        check("retrig_climb", audio_left, 16'h3000);
        at(70);
        set_ch(0, 20'd7, 15'h4000, 2'b11);
        ch_load = 2'b01;
        at(71);
        ch_load = '0;
        at(72);
        check("load_no_flip", audio_left, 16'hC000);
        at(79);
        check("div7_hold", audio_left, 16'hC000);
        at(80);
        check("div7_toggle", audio_left, 16'h4000);
        at(87);
        check("div7_hold2", audio_left, 16'h4000);
        at(88);
        check("div7_toggle2", audio_left, 16'hC000);
        rst = 1'b1; ch_gate = '0;
        at(89);
        check("rst2_busy", ch_busy, 2'b00);
        check("rst2_left", audio_left, 16'h0000);
        check("rst2_right", audio_right, 16'h0000);
        rst = 1'b0;
        set_ch(0, 20'd3, 15'h7FFF, 2'b11);
        set_ch(1, 20'd3, 15'h7FFF, 2'b11);
        ch_load = 2'b11; ch_gate = 2'b11;
        at(90);
        ch_load = '0;
        at(94);
        check("midatk_busy", ch_busy, 2'b11);
        rst = 1'b1;
        at(95);
        check("rst3_busy", ch_busy, 2'b00);
        check("rst3_left", audio_left, 16'h0000);
        check("rst3_right", audio_right, 16'h0000);
        rst = 1'b0;
        at(100);
        check("mute_busy", ch_busy, 2'b11);
        check("mute_left", audio_left, 16'h0000);
        check("mute_right", audio_right, 16'h0000);
        ch_load = 2'b11;
        at(101);
        ch_load = '0;
        at(132);
        check("sat_hi_left", audio_left, 16'h7FFF);
        check("sat_hi_right", audio_right, 16'h7FFF);
        at(134);
        check("sat_lo_left", audio_left, 16'h8000);
        check("sat_lo_right", audio_right, 16'h8000);
        at(138);
        check("sat_hi2_left", audio_left, 16'h7FFF);
        set_ch(0, 20'd3, 15'h2000, 2'b10);
        set_ch(1, 20'd3, 15'h3000, 2'b01);
        ch_load = 2'b11;
        at(139);
        ch_load = '0;
        at(164);
        check("pan_pos_left", audio_left, 16'h2000);
        check("pan_pos_right", audio_right, 16'h3000);
        at(168);
        check("pan_neg_left", audio_left, 16'hE000);
        check("pan_neg_right", audio_right, 16'hD000);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/poly_tone_mixer.md
Name: poly_tone_mixer

Overview:
Parametrised, polyphonic successor to the single-voice square-wave buzzer driver. It holds NUM_CH independent tone channels. Each channel has its own divider, a gated attack/release envelope and left/right routing. The channel outputs are mixed with saturation into registered stereo samples for the audio DAC serializer.

Parameters:
NUM_CH, 4, number of tone channels (1..8)
DIV_W, 20, width of each note divider
AMP_W, 16, signed sample width; per-channel magnitude is AMP_W-1 bits
ENV_DIV, 1024, clocks per envelope tick (>=1)
ENV_STEP, 64, magnitude change per envelope tick

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ch_load  in  NUM_CH  per-channel one-cycle pulse; latches that channel's note_div/volume/pan slice
ch_gate  in  NUM_CH  per-channel level; 1 = note held
note_div  in  NUM_CH*DIV_W  packed dividers; channel i at [i*DIV_W +: DIV_W]
volume  in  NUM_CH*(AMP_W-1)  packed target magnitudes
pan  in  NUM_CH*2  packed {left_en, right_en}
ch_busy  out  NUM_CH  state != IDLE
audio_left  out  AMP_W  signed two's-complement mixed sample
audio_right  out  AMP_W  signed two's-complement mixed sample

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - every channel: cnt=0, phase=0, env=0, state IDLE; latched div, volume and pan = 0.
  - ch_busy=0; audio_left=audio_right=0.
  - Applies mid-note, discarding all state.
- Divider, per channel:
  - If cnt==div_l: cnt<=0 and phase toggles. Otherwise cnt<=cnt+1.
  - Tone period is 2*(div_l+1) clocks.
  - div_l==0 means the channel is muted: it contributes 0 and phase is held.
- ch_load[i]:
  - div_l, vol_l and pan_l <= their input slices; cnt <= 0; phase is kept, so a note change causes no polarity glitch.
  - FSM state is unaffected.
- Envelope tick: one shared prescaler pulses tick once every ENV_DIV clocks, free-running from reset.
- FSM, per channel; state changes take effect on clk edges:
  - IDLE: if gate=1, go to ATTACK.
  - ATTACK: on tick, env <= min(env+ENV_STEP, vol_l). When env==vol_l, go to SUSTAIN. If gate=0, go to RELEASE.
  - SUSTAIN: env follows vol_l at ENV_STEP per tick in either direction. If gate=0, go to RELEASE.
  - RELEASE: on tick, env <= max(env-ENV_STEP, 0). When env==0, go to IDLE. If gate=1, go to ATTACK from the current env, with no reset to 0.
  - Env arithmetic uses AMP_W bits internally so it cannot wrap.
- Simultaneous events:
  - load and gate rise in the same cycle: the attack targets the newly loaded volume.
  - load during RELEASE: values are latched and the release continues.
  - tick in the same cycle as a state change: the step uses the new state's rule.
- Channel contribution: +env when phase=1, -env when phase=0; 0 if IDLE or div_l==0.
- Mix:
  - Left = sum of contributions with pan_l[1]=1; right = sum of contributions with pan_l[0]=1.
  - The sum is computed at AMP_W+clog2(NUM_CH) bits, then saturated to [-2^(AMP_W-1), 2^(AMP_W-1)-1].
- Latency: outputs are registered. audio_* at edge n+1 reflects phase/env after edge n (1 clock).
- ch_busy is registered together with state.

Decomposition:
- Shared package/include holds:
  - FSM encodings ST_IDLE, ST_ATTACK, ST_SUSTAIN, ST_RELEASE (2 bits)
  - default widths
  - saturation function sat_signed
- Sub-module tone_channel: divider, FSM and envelope for one channel, instantiated NUM_CH times by generate.
- The top level holds the tick prescaler, the unpack logic and the saturating mixer.

Test Plan:
1. NUM_CH=2, ENV_DIV=4, ENV_STEP=0x1000. ch0: div=3, vol=0x4000, pan=2'b11, load+gate -> phase toggles every 4 clk (period 8); env reaches 0x4000 after 4 ticks (16 clk); audio alternates 0x4000/0xC000 and ch_busy[0]=1.
2. Same setup, drop gate in SUSTAIN -> env falls 0x1000 per tick; ch_busy[0] deasserts one clk after env reaches 0; audio returns to 0.
3. Saturation: 2 channels at vol=0x7FFF, div=3, loaded in the same cycle, pan=11 -> both phases high gives 0x7FFF; both low gives 0x8000, with no wrap.
4. Panning: ch0 pan=10 vol=0x2000, ch1 pan=01 vol=0x3000 -> audio_left carries only ±0x2000 and audio_right only ±0x3000.
5. Retrigger: re-raise gate during RELEASE at env=0x2000 -> state ATTACK, env climbs from 0x2000; ch_load with div=7 mid-tone -> cnt restarts, period becomes 16, no phase flip on the load edge.
6. rst=1 mid-attack, asserted for 1 clk -> next edge all outputs 0, ch_busy=0; div=0 with gate held -> contribution stays 0.
